cgra_kernel_loader: RTL and testbench



---
 rtl/cgra_kernel_loader_pkg.sv | 21 ++
 rtl/cgra_kernel_loader.sv | 175 +++++++++++++++++
 tb/tb_cgra_kernel_loader.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cgra_kernel_loader_pkg.sv
// cgra_kernel_loader_pkg: shared FSM state encoding and kernel-table line sizing
//   state_t          : launch sequencer states
//   table_line_width : width of one packed kernel-table line {nr, ptr, loc, ctx}
package cgra_kernel_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        LOAD,
        DRAIN,
        START,
        RUN
    } state_t;

    function automatic int table_line_width(int cpw, int lipw, int ctxw);
        return 2 * cpw + lipw + ctxw;
    endfunction

    localparam int TABLE_LINE_WIDTH = table_line_width(9, 9, 9);

endpackage

// File: rtl/cgra_kernel_loader.sv
// cgra_kernel_loader: kernel launch sequencer (table lookup, constant streaming, CGRA start/wait)
//   clk_i/rst_i            : clock, synchronous active-high reset
//   launch_*               : launch request handshake (ready only in IDLE)
//   kt_*                   : kernel-table read port (combinational, same-cycle data)
//   cmem_*                 : constant memory read port (data one cycle after strobe)
//   const_wr_*             : constant register file write port
//   cgra_*                 : CGRA start pulse, held context/location pointers, done input
//   busy_o/done_o/err_o    : status; err_o only active with KERNEL_LOADER_BOUNDS_CHECK_EN defined
// Optional feature macro: KERNEL_LOADER_BOUNDS_CHECK_EN (reject constant ranges past the top of memory)
module cgra_kernel_loader
    import cgra_kernel_loader_pkg::*;
#(
    parameter int ADDR_WIDTH                         = 9,
    parameter int CONST_POINTER_WIDTH                = 9,
    parameter int LOCATION_INFORMATION_POINTER_WIDTH = 9,
    parameter int CONTEXT_POINTER_WIDTH              = 9,
    parameter int DATA_WIDTH                         = 32
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          launch_valid_i,
    output logic                                          launch_ready_o,
    input  logic [ADDR_WIDTH-1:0]                         launch_kernel_i,
    output logic [ADDR_WIDTH-1:0]                         kt_addr_o,
    input  logic [CONST_POINTER_WIDTH-1:0]                kt_nr_of_constants_i,
    input  logic [CONST_POINTER_WIDTH-1:0]                kt_constants_pointer_i,
    input  logic [LOCATION_INFORMATION_POINTER_WIDTH-1:0] kt_locationInformation_pointer_i,
    input  logic [CONTEXT_POINTER_WIDTH-1:0]              kt_context_pointer_i,
    output logic                                          cmem_rd_en_o,
    output logic [CONST_POINTER_WIDTH-1:0]                cmem_addr_o,
    input  logic [DATA_WIDTH-1:0]                         cmem_data_i,
    output logic                                          const_wr_en_o,
    output logic [CONST_POINTER_WIDTH-1:0]                const_wr_idx_o,
    output logic [DATA_WIDTH-1:0]                         const_wr_data_o,
    output logic                                          cgra_start_o,
    output logic [CONTEXT_POINTER_WIDTH-1:0]              cgra_context_o,
    output logic [LOCATION_INFORMATION_POINTER_WIDTH-1:0] cgra_locinfo_o,
    input  logic                                          cgra_done_i,
    output logic                                          busy_o,
    output logic                                          done_o,
    output logic                                          err_o
);

    localparam int CPW    = CONST_POINTER_WIDTH;
    localparam int LIPW   = LOCATION_INFORMATION_POINTER_WIDTH;
    localparam int CTXW   = CONTEXT_POINTER_WIDTH;
    localparam int LINE_W = table_line_width(CPW, LIPW, CTXW);
    localparam logic [CPW-1:0] ONE = 1;

    state_t            state;
    logic [ADDR_WIDTH-1:0] id_q;
    logic [LINE_W-1:0] line_q;
    logic [CPW-1:0]    cnt;
    logic              rd_en_q;
    logic [CPW-1:0]    addr_q;
    logic              wr_en_q;
    logic [CPW-1:0]    wr_idx_q;
    logic              start_q;
    logic [CTXW-1:0]   ctx_q;
    logic [LIPW-1:0]   loc_q;
    logic              done_q;

    logic [CPW-1:0]  nr_f;
    logic [CPW-1:0]  ptr_f;
    logic [LIPW-1:0] loc_f;
    logic [CTXW-1:0] ctx_f;

    assign nr_f  = line_q[LINE_W-1 -: CPW];
    assign ptr_f = line_q[LINE_W-CPW-1 -: CPW];
    assign loc_f = line_q[CTXW +: LIPW];
    assign ctx_f = line_q[0 +: CTXW];

`ifdef KERNEL_LOADER_BOUNDS_CHECK_EN
    logic           err_q;
    logic [CPW:0]   end_sum;
    logic           oob;
    // One bit wider so that ptr + nr landing exactly on 2^CPW is still in range.
    assign end_sum = {1'b0, kt_constants_pointer_i} + {1'b0, kt_nr_of_constants_i};
    assign oob     = end_sum > {1'b1, {CPW{1'b0}}};
    assign err_o   = err_q;
`else
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            id_q     <= '0;
            line_q   <= '0;
            cnt      <= '0;
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
            wr_en_q  <= 1'b0;
            wr_idx_q <= '0;
            start_q  <= 1'b0;
            ctx_q    <= '0;
            loc_q    <= '0;
            done_q   <= 1'b0;
`ifdef KERNEL_LOADER_BOUNDS_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            // Every read issued in LOAD becomes a write in the following cycle.
            wr_en_q  <= state == LOAD;
            wr_idx_q <= cnt;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            case (state)
                IDLE: if (launch_valid_i) begin
                    id_q  <= launch_kernel_i;
                    state <= LOOKUP;
`ifdef KERNEL_LOADER_BOUNDS_CHECK_EN
                    err_q <= 1'b0;
`endif
                end
                LOOKUP: begin
                    line_q <= {kt_nr_of_constants_i, kt_constants_pointer_i,
                               kt_locationInformation_pointer_i, kt_context_pointer_i};
                    cnt    <= '0;
                    addr_q <= kt_constants_pointer_i;
`ifdef KERNEL_LOADER_BOUNDS_CHECK_EN
                    if (oob) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                    end else
`endif
                    if (kt_nr_of_constants_i == '0) begin
                        state   <= START;
                        start_q <= 1'b1;
                        ctx_q   <= kt_context_pointer_i;
                        loc_q   <= kt_locationInformation_pointer_i;
                    end else begin
                        state   <= LOAD;
                        rd_en_q <= 1'b1;
                    end
                end
                LOAD: if (cnt == nr_f - ONE) begin
                    state   <= DRAIN;
                    rd_en_q <= 1'b0;
                end else begin
                    cnt    <= cnt + ONE;
                    addr_q <= ptr_f + cnt + ONE;
                end
                DRAIN: begin
                    state   <= START;
                    start_q <= 1'b1;
                    ctx_q   <= ctx_f;
                    loc_q   <= loc_f;
                end
                START: state <= RUN;
                RUN: if (cgra_done_i) begin
                    state  <= IDLE;
                    done_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign launch_ready_o  = state == IDLE;
    assign busy_o          = state != IDLE;
    assign kt_addr_o       = id_q;
    assign cmem_rd_en_o    = rd_en_q;
    assign cmem_addr_o     = addr_q;
    assign const_wr_en_o   = wr_en_q;
    assign const_wr_idx_o  = wr_idx_q;
    // Gated so the write data port reads zero whenever no write is in flight.
    assign const_wr_data_o = wr_en_q ? cmem_data_i : '0;
    assign cgra_start_o    = start_q;
    assign cgra_context_o  = ctx_q;
    assign cgra_locinfo_o  = loc_q;
    assign done_o          = done_q;

endmodule

// File: tb/tb_cgra_kernel_loader.sv
// tb_cgra_kernel_loader: table-driven, hand-written and random launches checked against a cycle-numbered event model
module tb_cgra_kernel_loader;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        launch_valid_i = 1'b0;
    logic        launch_ready_o;
    logic [8:0]  launch_kernel_i = '0;
    logic [8:0]  kt_addr_o;
    logic [8:0]  kt_nr, kt_ptr, kt_loc, kt_ctx;
    logic        cmem_rd_en_o;
    logic [8:0]  cmem_addr_o;
    logic [31:0] cmem_data_i = '0;
    logic        const_wr_en_o;
    logic [8:0]  const_wr_idx_o;
    logic [31:0] const_wr_data_o;
    logic        cgra_start_o;
    logic [8:0]  cgra_context_o;
    logic [8:0]  cgra_locinfo_o;
    logic        cgra_done_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    always #5 clk = ~clk;

    cgra_kernel_loader dut (
        .clk_i                            (clk),
        .rst_i                            (rst_i),
        .launch_valid_i                   (launch_valid_i),
        .launch_ready_o                   (launch_ready_o),
        .launch_kernel_i                  (launch_kernel_i),
        .kt_addr_o                        (kt_addr_o),
        .kt_nr_of_constants_i             (kt_nr),
        .kt_constants_pointer_i           (kt_ptr),
        .kt_locationInformation_pointer_i (kt_loc),
        .kt_context_pointer_i             (kt_ctx),
        .cmem_rd_en_o                     (cmem_rd_en_o),
        .cmem_addr_o                      (cmem_addr_o),
        .cmem_data_i                      (cmem_data_i),
        .const_wr_en_o                    (const_wr_en_o),
        .const_wr_idx_o                   (const_wr_idx_o),
        .const_wr_data_o                  (const_wr_data_o),
        .cgra_start_o                     (cgra_start_o),
        .cgra_context_o                   (cgra_context_o),
        .cgra_locinfo_o                   (cgra_locinfo_o),
        .cgra_done_i                      (cgra_done_i),
        .busy_o                           (busy_o),
        .done_o                           (done_o),
        .err_o                            (err_o)
    );

    logic [8:0]  t_nr[512], t_ptr[512], t_loc[512], t_ctx[512];
    logic [31:0] cmem[512];

    assign kt_nr  = t_nr[kt_addr_o];
    assign kt_ptr = t_ptr[kt_addr_o];
    assign kt_loc = t_loc[kt_addr_o];
    assign kt_ctx = t_ctx[kt_addr_o];

    always @(posedge clk) cmem_data_i <= cmem_rd_en_o ? cmem[cmem_addr_o] : 32'hDEADBEEF;

    int   checks = 0;
    int   errors = 0;
    bit   prev_err = 1'b0;
    logic [8:0] prev_ctx = '0, prev_loc = '0;

    typedef struct {
        string nm;
        int    k, nr, ptr, loc, ctx, run;
        bit    pulse;
        int    st, dn;
        bit    er;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cmp_q(input string nm, input logic [63:0] a[$], input logic [63:0] e[$]);
        int bad = -1;
        int n = a.size() > e.size() ? a.size() : e.size();
        for (int i = 0; i < n && bad < 0; i++)
            if (i >= a.size() || i >= e.size() || a[i] !== e[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s entry %0d actual=%0h (count %0d) required=%0h (count %0d)", nm, bad,
                     bad < a.size() ? a[bad] : 64'h0, a.size(), bad < e.size() ? e[bad] : 64'h0, e.size());
        end
    endtask

    task automatic expect_reset_outputs(input string nm);
        chk({nm, "_ready"}, {63'h0, launch_ready_o}, 64'h1);
        chk({nm, "_outs_a"}, {35'h0, kt_addr_o, cmem_rd_en_o, cmem_addr_o, const_wr_en_o, const_wr_idx_o}, 64'h0);
        chk({nm, "_outs_b"}, {10'h0, const_wr_data_o, cgra_start_o, cgra_context_o, cgra_locinfo_o,
                              busy_o, done_o, err_o}, 64'h0);
    endtask

    function automatic bit bounds_err(input int nr, input int ptr);
`ifdef KERNEL_LOADER_BOUNDS_CHECK_EN
        return ptr + nr > 512;
`else
        return 1'b0;
`endif
    endfunction

    // One launch from IDLE; cycle 0 is the accepting cycle, cycle n is observed at the n-th following negedge.
    task automatic launch(input string nm, input int k, input int nr, input int ptr, input int loc,
                          input int ctx, input int run, input bit pulse, input int st, input int dn, input bit er);
        logic [63:0] ra[$], re[$], wa[$], we[$];
        int st_a = -1, dn_a = -1, nstarts = 0, busy_n = 0;
        logic [8:0] ctx_d = '0, loc_d = '0;
        logic err_d = 1'b0, err1 = 1'b1, rdy_d = 1'b0;
        t_nr[k] = 9'(nr); t_ptr[k] = 9'(ptr); t_loc[k] = 9'(loc); t_ctx[k] = 9'(ctx);
        if (!er)
            for (int i = 0; i < nr; i++) begin
                re.push_back({16'(2 + i), 16'((ptr + i) % 512), 32'h0});
                we.push_back({16'(3 + i), 16'(i), cmem[(ptr + i) % 512]});
            end
        chk({nm, "_ready_idle"}, {63'h0, launch_ready_o}, 64'h1);
        chk({nm, "_err_held"}, {63'h0, err_o}, {63'h0, prev_err});
        launch_kernel_i = 9'(k);
        launch_valid_i  = 1'b1;
        for (int rel = 1; rel <= nr + run + 20 && dn_a < 0; rel++) begin
            @(negedge clk);
            launch_valid_i = 1'b0;
            if (cmem_rd_en_o) ra.push_back({16'(rel), 7'h0, cmem_addr_o, 32'h0});
            if (const_wr_en_o) wa.push_back({16'(rel), 7'h0, const_wr_idx_o, const_wr_data_o});
            if (cgra_start_o) begin
                nstarts++;
                if (st_a < 0) st_a = rel;
            end
            if (busy_o) busy_n++;
            if (rel == 1) err1 = err_o;
            if (done_o) begin
                dn_a  = rel;
                err_d = err_o;
                rdy_d = launch_ready_o;
                ctx_d = cgra_context_o;
                loc_d = cgra_locinfo_o;
            end
            cgra_done_i = (st_a >= 0 && rel == st_a + run) || (pulse && rel == 2);
        end
        cgra_done_i = 1'b0;
        cmp_q({nm, "_reads"}, ra, re);
        cmp_q({nm, "_writes"}, wa, we);
        chk({nm, "_start_cycle"}, 64'(st_a), 64'(st));
        chk({nm, "_start_count"}, 64'(nstarts), er ? 64'h0 : 64'h1);
        chk({nm, "_done_cycle"}, 64'(dn_a), 64'(dn));
        chk({nm, "_err"}, {63'h0, err_d}, {63'h0, er});
        chk({nm, "_err_cleared"}, {63'h0, err1}, 64'h0);
        chk({nm, "_ready_at_done"}, {63'h0, rdy_d}, 64'h1);
        chk({nm, "_busy_cycles"}, 64'(busy_n), 64'(dn - 1));
        chk({nm, "_ctx"}, {55'h0, ctx_d}, er ? {55'h0, prev_ctx} : 64'(ctx));
        chk({nm, "_loc"}, {55'h0, loc_d}, er ? {55'h0, prev_loc} : 64'(loc));
        prev_err = er;
        if (!er) begin
            prev_ctx = 9'(ctx);
            prev_loc = 9'(loc);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        for (int i = 0; i < 512; i++) begin
            t_nr[i] = '0; t_ptr[i] = '0; t_loc[i] = '0; t_ctx[i] = '0;
            cmem[i] = $urandom;
        end
        tbl[0] = '{"k3",      3, 4,   'h10,  'h05, 'h22, 3,  1'b0, 7,   11,  1'b0};
        tbl[1] = '{"nr0",     5, 0,   'h00,  'h00, 'h01, 10, 1'b0, 2,   13,  1'b0};
`ifdef KERNEL_LOADER_BOUNDS_CHECK_EN
        tbl[2] = '{"wrap",    9, 4,   'h1FE, 'h0A, 'h0B, 2,  1'b0, -1,  2,   1'b1};
`else
        tbl[2] = '{"wrap",    9, 4,   'h1FE, 'h0A, 'h0B, 2,  1'b0, 7,   10,  1'b0};
`endif
        tbl[3] = '{"edge512", 10, 4,  'h1FC, 'h01, 'h02, 1,  1'b1, 7,   9,   1'b0};
        tbl[4] = '{"one",     11, 1,  'h1FF, 'h03, 'h04, 2,  1'b0, 4,   7,   1'b0};
        tbl[5] = '{"max",     12, 511, 'h01, 'h06, 'h07, 1,  1'b0, 514, 516, 1'b0};

        repeat (3) @(negedge clk);
        expect_reset_outputs("reset");
        rst_i = 1'b0;
        @(negedge clk);

        foreach (tbl[i])
            launch(tbl[i].nm, tbl[i].k, tbl[i].nr, tbl[i].ptr, tbl[i].loc, tbl[i].ctx, tbl[i].run,
                   tbl[i].pulse, tbl[i].st, tbl[i].dn, tbl[i].er);

        // launch_valid_i held high and cgra_done_i high from LOOKUP on: only the RUN-state done counts,
        // and the still-high request is taken again in the done cycle.
        begin
            int st = -1, dn = -1, dn2 = -1, starts = 0;
            logic reacc = 1'b0;
            t_nr[7] = 9'd2; t_ptr[7] = 9'h040; t_ctx[7] = 9'h033; t_loc[7] = 9'h011;
            launch_kernel_i = 9'd7;
            launch_valid_i  = 1'b1;
            for (int rel = 1; rel <= 40 && dn2 < 0; rel++) begin
                @(negedge clk);
                cgra_done_i = 1'b1;
                if (cgra_start_o) begin
                    starts++;
                    if (st < 0) st = rel;
                end
                if (done_o && dn >= 0) dn2 = rel;
                if (done_o && dn < 0) dn = rel;
                if (dn >= 0 && rel == dn + 1) begin
                    reacc = busy_o;
                    launch_valid_i = 1'b0;
                end
            end
            cgra_done_i = 1'b0;
            chk("hold_start_cycle", 64'(st), 64'd5);
            chk("hold_done_cycle", 64'(dn), 64'd7);
            chk("hold_reaccept", {63'h0, reacc}, 64'h1);
            chk("hold_done2_cycle", 64'(dn2), 64'd14);
            chk("hold_start_count", 64'(starts), 64'd2);
            prev_ctx = 9'h033; prev_loc = 9'h011; prev_err = 1'b0;
        end

        // Reset during LOAD after two reads aborts everything.
        begin
            int nreads = 0, quiet = 0;
            launch_kernel_i = 9'd3;
            launch_valid_i  = 1'b1;
            for (int rel = 1; rel <= 3; rel++) begin
                @(negedge clk);
                launch_valid_i = 1'b0;
                if (cmem_rd_en_o) nreads++;
            end
            rst_i = 1'b1;
            @(negedge clk);
            expect_reset_outputs("rst_abort");
            rst_i = 1'b0;
            repeat (6) begin
                @(negedge clk);
                if (cmem_rd_en_o || const_wr_en_o || done_o || cgra_start_o || busy_o) quiet++;
            end
            chk("rst_reads_before", 64'(nreads), 64'd2);
            chk("rst_quiet_after", 64'(quiet), 64'd0);
            prev_ctx = '0; prev_loc = '0; prev_err = 1'b0;
        end

        for (int n = 0; n < 16; n++) begin
            int k   = $urandom_range(100, 499);
            int nr  = $urandom_range(0, 12);
            int ptr = ($urandom_range(0, 3) == 0) ? $urandom_range(500, 511) : $urandom_range(0, 511);
            int run = $urandom_range(1, 5);
            int loc = $urandom_range(0, 511);
            int ctx = $urandom_range(0, 511);
            bit er  = bounds_err(nr, ptr);
            int st  = er ? -1 : (nr == 0 ? 2 : nr + 3);
            int dn  = er ? 2 : st + run + 1;
            launch($sformatf("rnd%0d", n), k, nr, ptr, loc, ctx, run, n[0], st, dn, er);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
